// File: rtl/timer_irq_if.sv
// Peripheral data-memory bus between the CPU datapath and the interval timer.
// The CPU drives address/strobes/store data; the timer returns load data and its decode hit.
interface timer_irq_if;
  logic [31:0] addr;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hit;

  modport master (
    output addr,
    output rd_en,
    output wr_en,
    output wdata,
    input  rdata,
    input  hit
  );

  modport slave (
    input  addr,
    input  rd_en,
    input  wr_en,
    input  wdata,
    output rdata,
    output hit
  );
endinterface

// File: rtl/timer_irq.sv
// Memory-mapped interval timer: prescaled up-counter with reload from TH on overflow
// and a level interrupt that stays asserted until software clears the status bit.
module timer_irq #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          PRE_W     = 8
) (
  input  logic       clk,
  input  logic       reset,
  timer_irq_if.slave bus,
  output logic       irq
);

  localparam logic [1:0]       OFS_TH   = 2'd0;
  localparam logic [1:0]       OFS_TL   = 2'd1;
  localparam logic [1:0]       OFS_TCON = 2'd2;
  localparam logic [1:0]       OFS_PRE  = 2'd3;
  localparam logic [PRE_W-1:0] PRE_ONE  = {{(PRE_W-1){1'b0}}, 1'b1};
  localparam logic [31:0]      TL_MAX   = 32'hFFFF_FFFF;

  logic [31:0]      r_th;
  logic [31:0]      r_tl;
  logic             r_en;
  logic             r_ien;
  logic             r_status;
  logic [PRE_W-1:0] r_pre;
  logic [PRE_W-1:0] r_pcnt;

  logic [1:0]       w_sel;
  logic             w_hit;
  logic             w_wr;
  logic             w_wr_th;
  logic             w_wr_tl;
  logic             w_wr_tcon;
  logic             w_wr_pre;
  logic             w_tick;
  logic             w_ovf;
  logic [31:0]      w_rdata;
  logic             w_unused;

  assign w_sel     = bus.addr[3:2];
  assign w_hit     = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign w_wr      = bus.wr_en & w_hit;
  assign w_wr_th   = w_wr & (w_sel == OFS_TH);
  assign w_wr_tl   = w_wr & (w_sel == OFS_TL);
  assign w_wr_tcon = w_wr & (w_sel == OFS_TCON);
  assign w_wr_pre  = w_wr & (w_sel == OFS_PRE);
  assign w_unused  = ^bus.addr[1:0];

  // A PRE write restarts the prescaler from the new value, so it swallows this edge's tick.
  assign w_tick = r_en & (r_pcnt == '0) & ~w_wr_pre;
  assign w_ovf  = w_tick & (r_tl == TL_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pcnt <= '0;
    end else if (w_wr_pre) begin
      r_pcnt <= bus.wdata[PRE_W-1:0];
    end else if (!r_en || (r_pcnt == '0)) begin
      r_pcnt <= r_pre;
    end else begin
      r_pcnt <= r_pcnt - PRE_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pre <= '0;
    end else if (w_wr_pre) begin
      r_pre <= bus.wdata[PRE_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_th <= '0;
    end else if (w_wr_th) begin
      r_th <= bus.wdata;
    end
  end

  // Software writes to TL win over both increment and reload; reload sees pre-edge TH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tl <= '0;
    end else if (w_wr_tl) begin
      r_tl <= bus.wdata;
    end else if (w_ovf) begin
      r_tl <= r_th;
    end else if (w_tick) begin
      r_tl <= r_tl + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en  <= 1'b0;
      r_ien <= 1'b0;
    end else if (w_wr_tcon) begin
      r_en  <= bus.wdata[0];
      r_ien <= bus.wdata[1];
    end
  end

  // An overflow set takes priority over a software clear so no interrupt is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_status <= 1'b0;
    end else if (w_ovf && r_ien) begin
      r_status <= 1'b1;
    end else if (w_wr_tcon) begin
      r_status <= bus.wdata[2];
    end
  end

  always_comb begin
    w_rdata = '0;
    if (bus.rd_en && w_hit) begin
      case (w_sel)
        OFS_TH:   w_rdata = r_th;
        OFS_TL:   w_rdata = r_tl;
        OFS_TCON: w_rdata = {29'b0, r_status, r_ien, r_en};
        default:  w_rdata = 32'(r_pre);
      endcase
    end
  end

  assign bus.rdata = w_rdata;
  assign bus.hit   = w_hit;
  assign irq       = r_status & r_ien;

endmodule
